// File: rtl/pri_encoder_queue.sv
// Priority encoder with a sticky pending register and a one-entry registered
// output slot; selection is fixed-priority (highest index) or round-robin.
module pri_encoder_queue #(
  parameter int N          = 8,
  parameter int W          = $clog2(N),
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iEI,
  input  logic [N-1:0] iData,
  input  logic         iMode,
  input  logic         iReady,
  output logic [W-1:0] oData,
  output logic         oValid,
  output logic         oEO,
  output logic         oDrop
);

  localparam int WP = W + 1;

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] req;
  logic [N-1:0] clr_mask;
  logic [W-1:0] fixed_sel, rr_sel, sel;
  logic [WP-1:0] cand;
  logic         slot_free, load;

  // Handshake: oData is transferred on every rising edge where oValid and
  // iReady are both 1; while oValid=1 and iReady=0 the slot holds unchanged.
  always_comb begin
    req       = iData ^ {N{ACTIVE_LOW}};
    slot_free = !valid_q || iReady;

    fixed_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) fixed_sel = W'(i);
    end

    // Walk candidates from farthest (ptr itself) to nearest (ptr-1) so the
    // last hit is the first one in round-robin order.
    rr_sel = '0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + WP'(N - k);
      if (cand >= WP'(N)) cand = cand - WP'(N);
      if (pend_q[cand[W-1:0]]) rr_sel = cand[W-1:0];
    end

    sel      = iMode ? rr_sel : fixed_sel;
    load     = slot_free && (pend_q != '0);
    clr_mask = load ? (N'(1) << sel) : '0;

    // New requests are OR-ed after the clear so a same-edge set wins.
    pend_d = (pend_q & ~clr_mask) | (iEI ? req : '0);
    drop_d = iEI && ((req & pend_q & ~clr_mask) != '0);

    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (slot_free) begin
      valid_d = load;
      if (load) begin
        data_d = sel;
        ptr_d  = sel;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pend_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      ptr_q   <= ptr_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oDrop  = drop_q;
  assign oEO    = iEI && !iRst && !valid_q && (pend_q == '0);

endmodule

// File: doc/pri_encoder_queue.md
PRI_ENCODER_QUEUE -- requirements
Module: pri_encoder_queue

Interface
REQ-001 Parameter N, default 8, number of request lines (2..64).
REQ-002 Parameter W, default $clog2(N), width of encoded index.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = iData bit active at 0, 0 = active at 1.
REQ-004 iClk  input  1  sole clock; all state updates on rising edge.
REQ-005 iRst  input  1  synchronous, active-high reset.
REQ-006 iEI  input  1  enable input; 1 = capture requests.
REQ-007 iData  input  N  request lines, polarity per ACTIVE_LOW.
REQ-008 iMode  input  1  0 = fixed priority, 1 = round-robin.
REQ-009 iReady  input  1  consumer accepts oData this cycle.
REQ-010 oData  output  W  encoded index of granted request (registered).
REQ-011 oValid  output  1  oData holds a grant (registered).
REQ-012 oEO  output  1  enable output; 1 = enabled and fully idle.
REQ-013 oDrop  output  1  one-cycle pulse: a request coalesced into an already-pending bit (registered).

Function
REQ-014 req[i] SHALL be iData[i] XOR ACTIVE_LOW (bit active after polarity correction).
REQ-015 Pending register pend[N-1:0]: at each edge with iEI=1, pend |= req; with iEI=0, req is ignored and pend retained.
REQ-016 Output slot is free when oValid=0 or (oValid=1 and iReady=1).
REQ-017 When slot free and pend (current register value) nonzero, the edge SHALL load oData=selected index, oValid=1, and clear that bit from pend.
REQ-018 Same-edge set and clear of one pend bit: set wins (bit stays pending).
REQ-019 When slot free and pend zero, the edge SHALL set oValid=0; oData retains its last value.
REQ-020 While oValid=1 and iReady=0, oData and oValid SHALL hold unchanged.
REQ-021 Latency: request sampled at edge E0 appears on oValid/oData no earlier than edge E1 (requests never bypass pend).
REQ-022 Fixed mode: highest set index wins (index N-1 highest priority).
REQ-023 Round-robin: pointer ptr (W bits) = last loaded index; search order ptr-1, ptr-2, ... wrapping N-1 after 0, ptr itself last; ptr updates on every load in either mode.
REQ-024 Round-robin wrap: with ptr=0, first candidate is N-1.
REQ-025 iMode may change any cycle; it takes effect on the next selection; no state is flushed.
REQ-026 oDrop SHALL be 1 for the cycle after an edge where iEI=1 and req[i]=1 with pend[i] already 1 for any i (excluding the bit cleared at that edge).
REQ-027 oEO = iEI AND NOT iRst AND (oValid=0) AND (pend=0), combinational from registers.
REQ-028 Index encoding is plain binary, unused codes for non-power-of-2 N never produced.

Reset
REQ-029 With iRst=1 at an edge: pend=0, oValid=0, oData=0, oDrop=0, ptr=0; requests that cycle are discarded.
REQ-030 Reset mid-operation SHALL discard pending and in-slot grants with no grant emitted afterwards.
REQ-031 While iRst=1, oEO SHALL be 0.

Verification
REQ-032 Reset: iRst=1 two cycles, iData=8'hFF, ACTIVE_LOW=1 -> oValid=0, oData=0, oDrop=0, oEO=0; after release with iEI=1, oEO=1.
REQ-033 Fixed: N=8, iMode=0, iReady=1, single cycle iData=8'b0111_1110 -> oData=7 valid one cycle, then oData=0 valid one cycle, then oValid=0, oEO=1.
REQ-034 Backpressure: grant oData=5 with iReady=0 for 4 cycles while bit 6 requested -> oData=5 held stable; after iReady=1, next grant oData=6.
REQ-035 Round-robin: iMode=1, all 8 requests active continuously, iReady=1 -> grant sequence 7,6,5,4,3,2,1,0,7 (ptr starts 0).
REQ-036 Enable/coalesce: iEI=0 with requests -> no grants, oEO=0; iEI=1, bit 3 held two cycles while slot busy -> oDrop=1 one cycle, exactly one grant of 3.
REQ-037 Mid-operation reset: 3 bits pending, oValid=1, iRst=1 one cycle -> oValid=0 next cycle, no further grants without new requests.
